// File: rtl/parallax_scroll_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// parallax_scroll_ctrl_pkg
//
// Purpose: shared constants and types for the parallax scroll controller.
//   Holds the default geometry of the scroll accumulators, the encoding of the
//   configuration select bit and a helper that derives the fixed-point wrap
//   modulus from a pixel wrap width.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package parallax_scroll_ctrl_pkg;

  // Default geometry: 3 layers, 10-bit integer positions with 4 fractional
  // bits, signed Q4.4 speeds and a 640-pixel wrap.
  localparam int DEF_NUM_LAYERS = 3;
  localparam int DEF_POS_W      = 10;
  localparam int DEF_FRAC_W     = 4;
  localparam int DEF_SPEED_W    = 8;
  localparam int DEF_WRAP_X     = 640;

  // Width of the configuration write bus fields.
  localparam int CFG_DATA_W     = 16;
  localparam int CFG_LAYER_W    = 2;

  // Meaning of the cfg_sel bit on a configuration write.
  typedef enum logic {
    CFG_SEL_SPEED = 1'b0,
    CFG_SEL_POS   = 1'b1
  } cfg_sel_e;

  // Wrap modulus expressed in the fixed-point accumulator domain.
  function automatic int calcWrapFx(input int wrapX, input int fracW);
    return wrapX << fracW;
  endfunction

  localparam int DEF_WRAP_FX = calcWrapFx(DEF_WRAP_X, DEF_FRAC_W);

endpackage

// File: rtl/parallax_scroll_ctrl_if.sv
// ---------------------------------------------------------------------------
// parallax_scroll_ctrl_if
//
// Purpose: bundles every non-clock signal of the parallax scroll controller.
//
// Signals:
//   enable     scroll engine on
//   pause      freeze positions, frame counter still runs
//   vsync      positive-polarity vsync from the timing generator
//   cfg_we     single-cycle configuration write strobe
//   cfg_layer  target layer of the write
//   cfg_sel    0 = speed write, 1 = integer position write
//   cfg_data   write data (speed or position in the LSBs)
//   irq_clr    per-layer write-1-to-clear for wrap_flag
//   scroll_x   packed integer positions, layer 0 in the LSBs
//   frame_cnt  frames counted while enabled
//   frame_tick one-cycle pulse per counted frame
//   wrap_flag  sticky per-layer wrap indicator
//
// Modports: slave = controller side, master = register decode / timing side.
// ---------------------------------------------------------------------------
interface parallax_scroll_ctrl_if
  import parallax_scroll_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int POS_W      = DEF_POS_W
);

  logic                        enable;
  logic                        pause;
  logic                        vsync;
  logic                        cfg_we;
  logic [CFG_LAYER_W-1:0]      cfg_layer;
  logic                        cfg_sel;
  logic [CFG_DATA_W-1:0]       cfg_data;
  logic [NUM_LAYERS-1:0]       irq_clr;
  logic [NUM_LAYERS*POS_W-1:0] scroll_x;
  logic [15:0]                 frame_cnt;
  logic                        frame_tick;
  logic [NUM_LAYERS-1:0]       wrap_flag;

  modport slave (
    input  enable, pause, vsync,
    input  cfg_we, cfg_layer, cfg_sel, cfg_data,
    input  irq_clr,
    output scroll_x, frame_cnt, frame_tick, wrap_flag
  );

  modport master (
    output enable, pause, vsync,
    output cfg_we, cfg_layer, cfg_sel, cfg_data,
    output irq_clr,
    input  scroll_x, frame_cnt, frame_tick, wrap_flag
  );

endinterface

// File: rtl/parallax_scroll_ctrl_layer_acc.sv
// ---------------------------------------------------------------------------
// scroll_layer_acc
//
// Purpose: one background layer's scroll state. Holds the signed fractional
//   speed and the {pos, frac} accumulator, advances the accumulator by the
//   speed on each frame step, wraps it into [0, WRAP_X*2^FRAC_W) and keeps a
//   sticky wrap flag. A position write overrides the frame step of the same
//   cycle and suppresses the wrap flag for that cycle.
//
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   frame_i       advance the accumulator this cycle
//   speedWe_i     load speedData_i into the speed register
//   speedData_i   signed Q(SPEED_W-FRAC_W).FRAC_W speed
//   posWe_i       load posData_i (mod WRAP_X) as the integer position
//   posData_i     integer position to load
//   irqClr_i      clear the sticky wrap flag
//   pos_o         registered integer position
//   wrapFlag_o    sticky wrap indicator
// ---------------------------------------------------------------------------
module scroll_layer_acc
  import parallax_scroll_ctrl_pkg::*;
#(
  parameter int POS_W   = DEF_POS_W,
  parameter int FRAC_W  = DEF_FRAC_W,
  parameter int SPEED_W = DEF_SPEED_W,
  parameter int WRAP_X  = DEF_WRAP_X
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_i,
  input  logic               speedWe_i,
  input  logic [SPEED_W-1:0] speedData_i,
  input  logic               posWe_i,
  input  logic [POS_W-1:0]   posData_i,
  input  logic               irqClr_i,
  output logic [POS_W-1:0]   pos_o,
  output logic               wrapFlag_o
);

  localparam int ACC_W = POS_W + FRAC_W;
  // Two guard bits: one for the sign, one for overflow past the modulus.
  localparam int SUM_W = ACC_W + 2;
  localparam logic signed [SUM_W-1:0] WRAP_FX_S = SUM_W'(calcWrapFx(WRAP_X, FRAC_W));
  localparam logic [POS_W:0]          WRAP_X_P  = (POS_W+1)'(WRAP_X);

  logic [ACC_W-1:0]        acc_q, acc_d;
  logic [SPEED_W-1:0]      speed_q, speed_d;
  logic                    wrapFlag_q, wrapFlag_d;

  logic signed [SUM_W-1:0] accExt;
  logic signed [SUM_W-1:0] speedExt;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] sumWrapped;
  logic                    wrapHit;
  logic [POS_W:0]          posExt;
  logic [POS_W:0]          posWrapped;
  logic [SUM_W-ACC_W-1:0]  unusedSumBits;

  // Signed step of the accumulator. The accumulator is always in range and the
  // speed is smaller than the modulus, so at most one correction is needed.
  always_comb begin
    accExt     = {2'b00, acc_q};
    speedExt   = {{(SUM_W-SPEED_W){speed_q[SPEED_W-1]}}, speed_q};
    sum        = accExt + speedExt;
    sumWrapped = sum;
    wrapHit    = 1'b0;
    if (sum >= WRAP_FX_S) begin
      sumWrapped = sum - WRAP_FX_S;
      wrapHit    = 1'b1;
    end else if (sum[SUM_W-1]) begin
      sumWrapped = sum + WRAP_FX_S;
      wrapHit    = 1'b1;
    end
  end

  assign unusedSumBits = sumWrapped[SUM_W-1:ACC_W];

  // Position writes are folded into range with a single subtraction since the
  // write field can be at most 2^POS_W - 1 < 2*WRAP_X.
  always_comb begin
    posExt     = {1'b0, posData_i};
    posWrapped = posExt;
    if (posExt >= WRAP_X_P) begin
      posWrapped = posExt - WRAP_X_P;
    end
  end

  // Next-state selection: a position write beats the frame step; a speed write
  // only lands in the register, so the current frame still uses the old speed.
  // A wrap in the same cycle as irqClr keeps the flag set.
  always_comb begin
    acc_d      = acc_q;
    speed_d    = speed_q;
    wrapFlag_d = wrapFlag_q;
    if (posWe_i) begin
      acc_d = {posWrapped[POS_W-1:0], {FRAC_W{1'b0}}};
    end else if (frame_i) begin
      acc_d = sumWrapped[ACC_W-1:0];
    end
    if (speedWe_i) begin
      speed_d = speedData_i;
    end
    if (frame_i && !posWe_i && wrapHit) begin
      wrapFlag_d = 1'b1;
    end else if (irqClr_i) begin
      wrapFlag_d = 1'b0;
    end
  end

  // Layer state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      speed_q    <= '0;
      wrapFlag_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      speed_q    <= speed_d;
      wrapFlag_q <= wrapFlag_d;
    end
  end

  assign pos_o      = acc_q[ACC_W-1:FRAC_W];
  assign wrapFlag_o = wrapFlag_q;

endmodule

// File: rtl/parallax_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// parallax_scroll_ctrl
//
// Purpose: per-frame scroll-offset generator for the scrolling background.
//   Detects the rising edge of vsync, counts frames while enabled, emits a
//   one-cycle frame tick and steps one scroll accumulator per layer. Config
//   writes from the register decode load per-layer speeds and positions.
//
// Ports:
//   clk    peripheral clock
//   rst_n  asynchronous active-low reset
//   bus    slave side of parallax_scroll_ctrl_if (controls, config write port,
//          scroll_x / frame_cnt / frame_tick / wrap_flag outputs)
// ---------------------------------------------------------------------------
module parallax_scroll_ctrl
  import parallax_scroll_ctrl_pkg::*;
#(
  parameter int NUM_LAYERS = DEF_NUM_LAYERS,
  parameter int POS_W      = DEF_POS_W,
  parameter int FRAC_W     = DEF_FRAC_W,
  parameter int SPEED_W    = DEF_SPEED_W,
  parameter int WRAP_X     = DEF_WRAP_X
) (
  input logic                   clk,
  input logic                   rst_n,
  parallax_scroll_ctrl_if.slave bus
);

  logic                  vsync_q;
  logic                  vsyncArmed_q;
  logic [15:0]           frameCnt_q, frameCnt_d;
  logic                  frameTick_q, frameTick_d;

  logic                  vsyncEdge;
  logic                  frameEvt;
  logic                  layerStep;
  logic [NUM_LAYERS-1:0] speedWe;
  logic [NUM_LAYERS-1:0] posWe;
  logic [POS_W-1:0]      layerPos [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] layerWrap;
  logic                  unusedCfgBits;

  // vsync history. The armed bit is cleared by reset and only set once vsync
  // has been seen low, so a vsync held high through reset is not a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q      <= 1'b0;
      vsyncArmed_q <= 1'b0;
    end else begin
      vsync_q <= bus.vsync;
      if (!bus.vsync) begin
        vsyncArmed_q <= 1'b1;
      end
    end
  end

  assign vsyncEdge = bus.vsync & ~vsync_q & vsyncArmed_q;
  assign frameEvt  = vsyncEdge & bus.enable;
  assign layerStep = frameEvt & ~bus.pause;

  // Frame counter and tick: both advance only on an enabled frame edge.
  always_comb begin
    frameCnt_d  = frameCnt_q;
    frameTick_d = 1'b0;
    if (frameEvt) begin
      frameCnt_d  = frameCnt_q + 16'd1;
      frameTick_d = 1'b1;
    end
  end

  // Frame counter and tick registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frameCnt_q  <= '0;
      frameTick_q <= 1'b0;
    end else begin
      frameCnt_q  <= frameCnt_d;
      frameTick_q <= frameTick_d;
    end
  end

  // Config decode. Layer indices with no instance match nothing, which is how
  // writes to out-of-range layers are dropped.
  always_comb begin
    speedWe = '0;
    posWe   = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      if (bus.cfg_we && (bus.cfg_layer == CFG_LAYER_W'(l))) begin
        speedWe[l] = (bus.cfg_sel == CFG_SEL_SPEED);
        posWe[l]   = (bus.cfg_sel == CFG_SEL_POS);
      end
    end
  end

  assign unusedCfgBits = ^bus.cfg_data;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : gLayer
    scroll_layer_acc #(
      .POS_W   (POS_W),
      .FRAC_W  (FRAC_W),
      .SPEED_W (SPEED_W),
      .WRAP_X  (WRAP_X)
    ) uAcc (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_i     (layerStep),
      .speedWe_i   (speedWe[g]),
      .speedData_i (bus.cfg_data[SPEED_W-1:0]),
      .posWe_i     (posWe[g]),
      .posData_i   (bus.cfg_data[POS_W-1:0]),
      .irqClr_i    (bus.irq_clr[g]),
      .pos_o       (layerPos[g]),
      .wrapFlag_o  (layerWrap[g])
    );
  end

  // Output packing, layer 0 in the least significant slice.
  always_comb begin
    bus.scroll_x = '0;
    for (int l = 0; l < NUM_LAYERS; l++) begin
      bus.scroll_x[l*POS_W +: POS_W] = layerPos[l];
    end
  end

  assign bus.frame_cnt  = frameCnt_q;
  assign bus.frame_tick = frameTick_q;
  assign bus.wrap_flag  = layerWrap;

endmodule

// File: tb/tb_parallax_scroll_ctrl.sv
// ---------------------------------------------------------------------------
// tb_parallax_scroll_ctrl
//
// Purpose: directed self-checking bench for parallax_scroll_ctrl with
//   3 layers, 10-bit positions, Q4.4 speeds and a 640-pixel wrap.
// ---------------------------------------------------------------------------
module tb_parallax_scroll_ctrl;
  import parallax_scroll_ctrl_pkg::*;

  localparam int NL = 3;
  localparam int PW = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   compared = 0;
  int   mismatched = 0;

  parallax_scroll_ctrl_if #(.NUM_LAYERS(NL), .POS_W(PW)) busIf ();

  parallax_scroll_ctrl #(
    .NUM_LAYERS (NL),
    .POS_W      (PW),
    .FRAC_W     (4),
    .SPEED_W    (8),
    .WRAP_X     (640)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (busIf)
  );

  // Free-running 100 MHz clock.
  always #5 clk = ~clk;

  // Absolute time limit so a stuck run still ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // One configuration write, one cycle wide, launched on a falling edge.
  task automatic cfgWrite(input logic [1:0] layer, input logic sel, input logic [15:0] data);
    @(negedge clk);
    busIf.cfg_we    = 1'b1;
    busIf.cfg_layer = layer;
    busIf.cfg_sel   = sel;
    busIf.cfg_data  = data;
    @(negedge clk);
    busIf.cfg_we    = 1'b0;
  endtask

  // One vsync pulse with optional same-cycle irq_clr; returns on the falling
  // edge right after the updating rising edge.
  task automatic applyStimulus(input logic [NL-1:0] clrMask);
    @(negedge clk);
    busIf.vsync   = 1'b1;
    busIf.irq_clr = clrMask;
    @(negedge clk);
    busIf.vsync   = 1'b0;
    busIf.irq_clr = '0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    compared++;
    if (busIf.scroll_x !== 30'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_scroll: got %h expected %h", busIf.scroll_x, 30'd0);
    end
    compared++;
    if (busIf.frame_cnt !== 16'd0) begin
      mismatched++;
      $display("[TB] FAIL reset_frame_cnt: got %0d expected 0", busIf.frame_cnt);
    end
    compared++;
    if (busIf.frame_tick !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_tick: got %b expected 0", busIf.frame_tick);
    end
    compared++;
    if (busIf.wrap_flag !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL reset_wrap: got %b expected 000", busIf.wrap_flag);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic_scroll();
    busIf.enable = 1'b1;
    cfgWrite(2'd0, CFG_SEL_SPEED, 16'h0010);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus('0);
      compared++;
      if (busIf.scroll_x !== {10'd0, 10'd0, 10'(i)}) begin
        mismatched++;
        $display("[TB] FAIL basic_scroll%0d: got %h expected %h", i, busIf.scroll_x, {10'd0, 10'd0, 10'(i)});
      end
      compared++;
      if (busIf.frame_tick !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL basic_tick_high%0d: got %b expected 1", i, busIf.frame_tick);
      end
      @(negedge clk);
      compared++;
      if (busIf.frame_tick !== 1'b0) begin
        mismatched++;
        $display("[TB] FAIL basic_tick_low%0d: got %b expected 0", i, busIf.frame_tick);
      end
    end
    compared++;
    if (busIf.frame_cnt !== 16'd3) begin
      mismatched++;
      $display("[TB] FAIL basic_frame_cnt: got %0d expected 3", busIf.frame_cnt);
    end
    compared++;
    if (busIf.wrap_flag !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL basic_wrap: got %b expected 000", busIf.wrap_flag);
    end
  endtask

  task automatic test_negative_wrap();
    cfgWrite(2'd0, CFG_SEL_SPEED, 16'h0000);
    cfgWrite(2'd1, CFG_SEL_POS, 16'd0);
    cfgWrite(2'd1, CFG_SEL_SPEED, 16'h00F8);
    applyStimulus('0);
    compared++;
    if (busIf.scroll_x !== {10'd0, 10'd639, 10'd3}) begin
      mismatched++;
      $display("[TB] FAIL neg_wrap_pos: got %h expected %h", busIf.scroll_x, {10'd0, 10'd639, 10'd3});
    end
    compared++;
    if (busIf.wrap_flag !== 3'b010) begin
      mismatched++;
      $display("[TB] FAIL neg_wrap_flag: got %b expected 010", busIf.wrap_flag);
    end
    compared++;
    if (busIf.frame_cnt !== 16'd4) begin
      mismatched++;
      $display("[TB] FAIL neg_wrap_cnt: got %0d expected 4", busIf.frame_cnt);
    end
    @(negedge clk);
    busIf.irq_clr = 3'b010;
    @(negedge clk);
    busIf.irq_clr = 3'b000;
    compared++;
    if (busIf.wrap_flag !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL neg_wrap_clear: got %b expected 000", busIf.wrap_flag);
    end
    // 639 + 8/16 - 8/16 lands exactly on 639.0 without wrapping.
    applyStimulus('0);
    compared++;
    if (busIf.scroll_x !== {10'd0, 10'd639, 10'd3}) begin
      mismatched++;
      $display("[TB] FAIL neg_frac_carry: got %h expected %h", busIf.scroll_x, {10'd0, 10'd639, 10'd3});
    end
    compared++;
    if (busIf.wrap_flag !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL neg_no_wrap: got %b expected 000", busIf.wrap_flag);
    end
    cfgWrite(2'd1, CFG_SEL_SPEED, 16'h0000);
  endtask

  task automatic test_positive_wrap();
    cfgWrite(2'd2, CFG_SEL_POS, 16'd636);
    cfgWrite(2'd2, CFG_SEL_SPEED, 16'h007F);
    applyStimulus('0);
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd639, 10'd3}) begin
      mismatched++;
      $display("[TB] FAIL pos_wrap_pos: got %h expected %h", busIf.scroll_x, {10'd3, 10'd639, 10'd3});
    end
    compared++;
    if (busIf.wrap_flag !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL pos_wrap_flag: got %b expected 100", busIf.wrap_flag);
    end
    cfgWrite(2'd2, CFG_SEL_POS, 16'd636);
    applyStimulus(3'b100);
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd639, 10'd3}) begin
      mismatched++;
      $display("[TB] FAIL pos_wrap2_pos: got %h expected %h", busIf.scroll_x, {10'd3, 10'd639, 10'd3});
    end
    compared++;
    if (busIf.wrap_flag !== 3'b100) begin
      mismatched++;
      $display("[TB] FAIL set_beats_clear: got %b expected 100", busIf.wrap_flag);
    end
    @(negedge clk);
    busIf.irq_clr = 3'b100;
    @(negedge clk);
    busIf.irq_clr = 3'b000;
    compared++;
    if (busIf.wrap_flag !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL pos_wrap_clear: got %b expected 000", busIf.wrap_flag);
    end
    cfgWrite(2'd2, CFG_SEL_SPEED, 16'h0000);
  endtask

  task automatic test_write_collision();
    cfgWrite(2'd0, CFG_SEL_SPEED, 16'h0010);
    cfgWrite(2'd0, CFG_SEL_POS, 16'd50);
    // Position write on the same cycle as the vsync edge.
    @(negedge clk);
    busIf.vsync     = 1'b1;
    busIf.cfg_we    = 1'b1;
    busIf.cfg_layer = 2'd0;
    busIf.cfg_sel   = CFG_SEL_POS;
    busIf.cfg_data  = 16'd100;
    @(negedge clk);
    busIf.vsync     = 1'b0;
    busIf.cfg_we    = 1'b0;
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd639, 10'd100}) begin
      mismatched++;
      $display("[TB] FAIL pos_write_wins: got %h expected %h", busIf.scroll_x, {10'd3, 10'd639, 10'd100});
    end
    compared++;
    if (busIf.wrap_flag !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL pos_write_no_flag: got %b expected 000", busIf.wrap_flag);
    end
    applyStimulus('0);
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd639, 10'd101}) begin
      mismatched++;
      $display("[TB] FAIL after_pos_write: got %h expected %h", busIf.scroll_x, {10'd3, 10'd639, 10'd101});
    end
    // Speed write on the same cycle as the vsync edge: old speed used now.
    @(negedge clk);
    busIf.vsync     = 1'b1;
    busIf.cfg_we    = 1'b1;
    busIf.cfg_layer = 2'd0;
    busIf.cfg_sel   = CFG_SEL_SPEED;
    busIf.cfg_data  = 16'h0020;
    @(negedge clk);
    busIf.vsync     = 1'b0;
    busIf.cfg_we    = 1'b0;
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd639, 10'd102}) begin
      mismatched++;
      $display("[TB] FAIL speed_write_old: got %h expected %h", busIf.scroll_x, {10'd3, 10'd639, 10'd102});
    end
    applyStimulus('0);
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd639, 10'd104}) begin
      mismatched++;
      $display("[TB] FAIL speed_write_new: got %h expected %h", busIf.scroll_x, {10'd3, 10'd639, 10'd104});
    end
    // Layer 3 does not exist; both writes must be dropped.
    cfgWrite(2'd3, CFG_SEL_POS, 16'd5);
    cfgWrite(2'd3, CFG_SEL_SPEED, 16'h0010);
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd639, 10'd104}) begin
      mismatched++;
      $display("[TB] FAIL bad_layer_ignored: got %h expected %h", busIf.scroll_x, {10'd3, 10'd639, 10'd104});
    end
    cfgWrite(2'd1, CFG_SEL_POS, 16'd700);
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd60, 10'd104}) begin
      mismatched++;
      $display("[TB] FAIL pos_write_mod: got %h expected %h", busIf.scroll_x, {10'd3, 10'd60, 10'd104});
    end
  endtask

  task automatic test_pause();
    busIf.pause = 1'b1;
    applyStimulus('0);
    applyStimulus('0);
    busIf.pause = 1'b0;
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd60, 10'd104}) begin
      mismatched++;
      $display("[TB] FAIL pause_hold: got %h expected %h", busIf.scroll_x, {10'd3, 10'd60, 10'd104});
    end
    compared++;
    if (busIf.frame_cnt !== 16'd13) begin
      mismatched++;
      $display("[TB] FAIL pause_cnt: got %0d expected 13", busIf.frame_cnt);
    end
  endtask

  task automatic test_disable();
    busIf.enable = 1'b0;
    applyStimulus('0);
    compared++;
    if (busIf.frame_tick !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL disable_tick: got %b expected 0", busIf.frame_tick);
    end
    compared++;
    if (busIf.frame_cnt !== 16'd13) begin
      mismatched++;
      $display("[TB] FAIL disable_cnt: got %0d expected 13", busIf.frame_cnt);
    end
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd60, 10'd104}) begin
      mismatched++;
      $display("[TB] FAIL disable_hold: got %h expected %h", busIf.scroll_x, {10'd3, 10'd60, 10'd104});
    end
    cfgWrite(2'd1, CFG_SEL_POS, 16'd7);
    compared++;
    if (busIf.scroll_x !== {10'd3, 10'd7, 10'd104}) begin
      mismatched++;
      $display("[TB] FAIL disable_cfg_write: got %h expected %h", busIf.scroll_x, {10'd3, 10'd7, 10'd104});
    end
    busIf.enable = 1'b1;
  endtask

  task automatic test_reset_vsync_high();
    @(negedge clk);
    busIf.vsync = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    compared++;
    if (busIf.frame_cnt !== 16'd0 || busIf.scroll_x !== 30'd0 || busIf.wrap_flag !== 3'b000) begin
      mismatched++;
      $display("[TB] FAIL midrun_reset: got cnt=%0d scroll=%h wrap=%b expected 0/0/0",
               busIf.frame_cnt, busIf.scroll_x, busIf.wrap_flag);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    compared++;
    if (busIf.frame_cnt !== 16'd0 || busIf.frame_tick !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL vsync_high_after_reset: got cnt=%0d tick=%b expected 0/0",
               busIf.frame_cnt, busIf.frame_tick);
    end
    busIf.vsync = 1'b0;
    applyStimulus('0);
    compared++;
    if (busIf.frame_cnt !== 16'd1 || busIf.frame_tick !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL first_frame_after_reset: got cnt=%0d tick=%b expected 1/1",
               busIf.frame_cnt, busIf.frame_tick);
    end
  endtask

  // Scenario sequence; each scenario carries on from the state the previous
  // one left behind.
  initial begin
    busIf.enable    = 1'b0;
    busIf.pause     = 1'b0;
    busIf.vsync     = 1'b0;
    busIf.cfg_we    = 1'b0;
    busIf.cfg_layer = 2'd0;
    busIf.cfg_sel   = 1'b0;
    busIf.cfg_data  = 16'd0;
    busIf.irq_clr   = '0;
    $display("[TB] starting parallax_scroll_ctrl bench");
    test_reset();
    test_basic_scroll();
    test_negative_wrap();
    test_positive_wrap();
    test_write_collision();
    test_pause();
    test_disable();
    test_reset_vsync_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/parallax_scroll_ctrl.md
Name: parallax_scroll_ctrl

Overview:
Per-frame scroll-offset generator that sits directly upstream of the background pixel generators in the scrolling-background peripheral. It watches vsync from the video timing generator and, once per frame, advances one horizontal scroll position per background layer by a signed fractional speed. It also wraps positions modulo the line width and publishes integer offsets plus a frame counter. Software configures speeds and positions through a simple write port driven by the peripheral register decode.

Parameters:
NUM_LAYERS, 3, number of background layers (1..4)
POS_W, 10, integer scroll position width in pixels
FRAC_W, 4, fractional bits of position and speed
SPEED_W, 8, signed speed width (Q(SPEED_W-FRAC_W).FRAC_W, px/frame)
WRAP_X, 640, wrap modulus in pixels; must exceed max |speed| and be <= 2^POS_W

Ports:
clk  in  1  peripheral clock (64 MHz)
rst_n  in  1  asynchronous active-low reset
enable  in  1  scroll engine on (the peripheral's stream mode)
pause  in  1  freeze positions; frame counter still runs
vsync  in  1  positive-polarity vsync from the timing generator
cfg_we  in  1  single-cycle config write strobe
cfg_layer  in  2  target layer index
cfg_sel  in  1  0 = write speed, 1 = write integer position
cfg_data  in  16  speed in [SPEED_W-1:0], or position in [POS_W-1:0]
irq_clr  in  NUM_LAYERS  per-layer write-1-to-clear for wrap_flag
scroll_x  out  NUM_LAYERS*POS_W  integer positions, layer 0 in LSBs
frame_cnt  out  16  frames counted while enabled
frame_tick  out  1  one-cycle pulse per counted frame
wrap_flag  out  NUM_LAYERS  sticky per-layer wrap indicator

Behaviour:
- Reset (async assert, sync release): all positions, fractions, speeds, frame_cnt, frame_tick, wrap_flag and vsync_q = 0.
- Edge detect: vsync_q <= vsync every cycle regardless of enable. Define edge = vsync & ~vsync_q.
- Frame update: when edge and enable are true before clock edge k, then after edge k:
  - frame_cnt increments (wraps 0xFFFF->0).
  - frame_tick = 1 for exactly one cycle.
  - if !pause, each layer updates acc <= acc + sign_extend(speed).
- Latency: if vsync is 0 at edge k-1 and 1 at edge k, the new scroll_x is visible after edge k.
- Accumulator: {pos, frac} is POS_W+FRAC_W bits, kept in [0, WRAP_X*2^FRAC_W).
  - Compute the sum at POS_W+FRAC_W+2 bits, signed.
  - If sum >= WRAP_X*2^FRAC_W, subtract that value. If sum < 0, add it.
  - Either case sets wrap_flag[layer].
- scroll_x outputs the registered integer part only.
- enable = 0: positions, frame_cnt and frame_tick hold, frame_tick stays 0; config writes are still accepted.
- Config write, cfg_we with cfg_layer < NUM_LAYERS:
  - cfg_sel = 0: speed <= cfg_data[SPEED_W-1:0].
  - cfg_sel = 1: pos <= cfg_data[POS_W-1:0] mod WRAP_X (values >= WRAP_X have WRAP_X subtracted once), frac <= 0.
  - cfg_layer >= NUM_LAYERS is ignored.
- Write vs frame update in the same cycle:
  - A position write wins for its layer; no wrap_flag is set for that layer.
  - A speed write takes effect from the next frame; the current frame uses the old speed.
  - Other layers update normally.
- wrap_flag vs irq_clr in the same cycle: set wins.
- Async reset mid-frame: everything returns to reset values immediately. The first edge after release requires vsync sampled 0 first, so a vsync held high through reset does not count as a frame.

Decomposition:
- Shared package scroll_pkg holds:
  - WRAP_X, POS_W, FRAC_W and SPEED_W defaults.
  - CFG_SEL_SPEED = 0 and CFG_SEL_POS = 1.
  - Derived constant WRAP_FX = WRAP_X << FRAC_W.
- Sub-module scroll_layer_acc, one instance per layer, contains:
  - Speed register and accumulator.
  - Wrap logic and write override.
  - Its own sticky wrap flag.
- The top level holds the edge detect, frame counter, config decode and output packing.

Test Plan:
- Reset, enable = 1, layer0 speed 0x10 (+1.0), three vsync pulses -> scroll_x[0] = 1, 2, 3; frame_cnt = 3; three single-cycle frame_ticks; wrap_flag = 0.
- Layer1 position 0, speed 0xF8 (-0.5), one vsync -> layer1 = 639 (frac 8), wrap_flag[1] = 1. Then irq_clr[1] -> flag clears.
- Layer2 position 636, speed 0x7F (+7.9375), one vsync -> layer2 = 3, wrap_flag[2] = 1. Same-cycle irq_clr[2] with a second wrapping frame -> flag stays 1.
- Layer0 speed +1.0 at position 50; position write of 100 asserted in the same cycle as the vsync edge -> layer0 = 100 (not 51), no wrap flag. The next frame gives 101.
- Two separate checks:
  - pause = 1 for two frames -> positions hold, frame_cnt +2.
  - enable = 0 -> frame_cnt and positions hold, frame_tick stays 0.
- vsync held high across an rst_n pulse -> after release, no frame counted until vsync falls and rises again.
